// File: rtl/pq_addr_ctrl.sv
// Ping-pong RAM address controller: fills one bank linearly, drains the other (optionally transposed).
// Latency: out_valid trails read issue by RD_LAT enabled cycles; in_ready drops from the last fill accept until the bank swap.
module pq_addr_ctrl #(
    parameter int ADDRLENGTH = 12,
    parameter int ADDRWDELAY = 10,
    parameter int TRANSPOSE  = 1,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr,
    output logic                  cen,
    output logic [ADDRLENGTH-1:0] addr_w,
    output logic [ADDRLENGTH-1:0] addr_r,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  overflow
);

    localparam int HALF       = ADDRLENGTH / 2;
    localparam int DRAIN_LAST = (ADDRWDELAY > 2) ? ADDRWDELAY - 2 : 0;
    localparam int DW         = (ADDRWDELAY > 2) ? $clog2(ADDRWDELAY) : 1;
    localparam logic [ADDRLENGTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {W_FILL, W_DRAIN, W_WAIT} wstate_t;
    typedef enum logic {R_IDLE, R_READ} rstate_t;

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic [ADDRLENGTH-1:0] r_wcnt, w_wcnt_nxt;
    logic [ADDRLENGTH-1:0] r_rcnt, w_rcnt_nxt;
    logic [DW-1:0]         r_dcnt, w_dcnt_nxt;
    logic [ADDRLENGTH-1:0] r_addr_hold;
    logic                  r_wr;
    logic                  r_ovf;
    logic [RD_LAT-1:0]     r_vld_pipe;
    logic [RD_LAT-1:0]     r_last_pipe;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_rd_issue;
    logic                  w_rd_final;
    logic                  w_swap;
    logic [ADDRLENGTH-1:0] w_addr_map;

    assign w_in_ready = (r_wstate == W_FILL) && !rst;
    assign w_accept   = enable && in_valid && w_in_ready;
    assign w_rd_issue = enable && (r_rstate == R_READ);
    assign w_rd_final = w_rd_issue && (r_rcnt == CNT_MAX);
    assign w_swap     = enable && (r_wstate == W_WAIT) &&
                        ((r_rstate == R_IDLE) || w_rd_final);

    generate
        if (TRANSPOSE != 0) begin : g_transpose
            assign w_addr_map = {r_rcnt[HALF-1:0], r_rcnt[ADDRLENGTH-1:HALF]};
        end else begin : g_linear
            assign w_addr_map = r_rcnt;
        end
    endgenerate

    // Drain is counted from the final accept, so the swap lands exactly
    // ADDRWDELAY enabled cycles after the last write address was issued.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_dcnt_nxt   = r_dcnt;
        case (r_wstate)
            W_FILL: begin
                if (w_accept) begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                    if (r_wcnt == CNT_MAX) begin
                        w_wstate_nxt = (ADDRWDELAY > 1) ? W_DRAIN : W_WAIT;
                        w_dcnt_nxt   = '0;
                    end
                end
            end
            W_DRAIN: begin
                if (enable) begin
                    if (r_dcnt == DW'(DRAIN_LAST)) begin
                        w_wstate_nxt = W_WAIT;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 1'b1;
                    end
                end
            end
            W_WAIT: begin
                if (w_swap) begin
                    w_wstate_nxt = W_FILL;
                end
            end
            default: w_wstate_nxt = W_FILL;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        if (w_rd_issue) begin
            w_rcnt_nxt = r_rcnt + 1'b1;
            if (r_rcnt == CNT_MAX) begin
                w_rstate_nxt = R_IDLE;
            end
        end
        if (w_swap) begin
            w_rstate_nxt = R_READ;
            w_rcnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate    <= W_FILL;
            r_rstate    <= R_IDLE;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_dcnt      <= '0;
            r_addr_hold <= '0;
            r_wr        <= 1'b0;
            r_ovf       <= 1'b0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            if (w_swap) begin
                r_wr <= ~r_wr;
            end
            if (w_rd_issue) begin
                r_addr_hold <= w_addr_map;
            end
            if (enable && in_valid && !w_in_ready) begin
                r_ovf <= 1'b1;
            end
            if (enable) begin
                for (int i = RD_LAT - 1; i > 0; i--) begin
                    r_vld_pipe[i]  <= r_vld_pipe[i-1];
                    r_last_pipe[i] <= r_last_pipe[i-1];
                end
                r_vld_pipe[0]  <= w_rd_issue;
                r_last_pipe[0] <= w_rd_final;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign wr        = r_wr & ~rst;
    assign cen       = rst;
    assign addr_w    = rst ? '0 : r_wcnt;
    assign addr_r    = rst ? '0 : ((r_rstate == R_READ) ? w_addr_map : r_addr_hold);
    assign out_valid = r_vld_pipe[RD_LAT-1] & ~rst;
    assign out_last  = r_last_pipe[RD_LAT-1] & ~rst;
    assign overflow  = r_ovf & ~rst;

endmodule
